// File: rtl/cp0_timer_ng.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, the exception/interrupt
// request, and an optional free-running Count/Compare timer.
module cp0_timer_ng #(
  parameter int          HW_INT_N = 6,
  parameter bit          TIMER_EN = 1'b0,
  parameter logic [31:0] PRID     = 32'h0000_5A01,
  parameter int          VPC_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          a,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  input  logic                bd_in,
  input  logic [VPC_W-1:0]    vpc,
  input  logic [4:0]          exc_code_in,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic                exl_clr,
  output logic                req,
  output logic [VPC_W-1:0]    epc_out,
  output logic                timer_irq
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]          sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [4:0]          cause_exc;
  logic [HW_INT_N-1:0] hw_int_q;
  logic [VPC_W-1:0]    epc;
  logic [VPC_W-1:0]    epc_next;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic                timer_pend;
  logic [5:0]          ip;
  logic                int_req;
  logic                exc_req;
  logic                mtc0;

  // The timer occupies the first IP slot above the external lines.
  assign ip = 6'(hw_int_q) | (TIMER_EN ? (6'(timer_pend) << HW_INT_N) : 6'd0);

  assign int_req   = sr_ie & ~sr_exl & (|(ip & sr_im));
  assign exc_req   = (exc_code_in != 5'd0) & ~sr_exl;
  assign req       = int_req | exc_req;
  assign mtc0      = we & ~req;
  assign epc_out   = epc;
  assign timer_irq = timer_pend;
  assign epc_next  = (bd_in ? (vpc - VPC_W'(4)) : vpc) & ~VPC_W'(3);

  always_comb begin
    dout = 32'd0;
    case (a)
      A_SR:      dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      A_CAUSE:   dout = {cause_bd, 15'd0, ip, 3'd0, cause_exc, 2'd0};
      A_EPC:     dout = 32'(epc);
      A_PRID:    dout = PRID;
      A_COUNT:   dout = count;
      A_COMPARE: dout = compare;
      default:   dout = 32'd0;
    endcase
  end

  // Taking a request overrides both eret and any mtc0 in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
      hw_int_q  <= '0;
      epc       <= '0;
    end else begin
      hw_int_q <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= int_req ? 5'd0 : exc_code_in;
        epc       <= epc_next;
      end else begin
        if (exl_clr) sr_exl <= 1'b0;
        if (we) begin
          case (a)
            A_SR: begin
              sr_im  <= din[15:10];
              sr_exl <= din[1];
              sr_ie  <= din[0];
            end
            A_EPC:   epc <= din[VPC_W-1:0] & ~VPC_W'(3);
            default: ;
          endcase
        end
      end
    end
  end

  // Timer runs independently of exceptions; a Compare write acknowledges it.
  always_ff @(posedge clk) begin
    if (reset || !TIMER_EN) begin
      count      <= 32'd0;
      compare    <= 32'd0;
      timer_pend <= 1'b0;
    end else begin
      count <= (mtc0 && a == A_COUNT) ? din : count + 32'd1;
      if (mtc0 && a == A_COMPARE) begin
        compare    <= din;
        timer_pend <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        timer_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_ng.sv
// Directed bench for cp0_timer_ng (5 external lines + timer); expectations are
// queued by the stimulus and checked by a negedge monitor.
module tb_cp0_timer_ng;

  typedef enum logic [1:0] {K_DOUT, K_REQ, K_EPC, K_TIRQ} kind_t;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  a;
  logic [31:0] din;
  logic [31:0] dout;
  logic        bd_in;
  logic [31:0] vpc;
  logic [4:0]  exc_code_in;
  logic [4:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;
  logic        timer_irq;

  kind_t       kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          failures;

  cp0_timer_ng #(
    .HW_INT_N(5),
    .TIMER_EN(1'b1),
    .PRID    (32'h0000_5A01),
    .VPC_W   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .a          (a),
    .din        (din),
    .dout       (dout),
    .bd_in      (bd_in),
    .vpc        (vpc),
    .exc_code_in(exc_code_in),
    .hw_int     (hw_int),
    .exl_clr    (exl_clr),
    .req        (req),
    .epc_out    (epc_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int w, input int addr, input logic [31:0] d,
                               input logic [31:0] pc, input int bd, input int exc,
                               input int hw, input int clr);
    we          = 1'(w);
    a           = 5'(addr);
    din         = d;
    vpc         = pc;
    bd_in       = 1'(bd);
    exc_code_in = 5'(exc);
    hw_int      = 5'(hw);
    exl_clr     = 1'(clr);
  endtask

  task automatic checkOutput(input kind_t k, input logic [31:0] e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: combinational outputs are stable mid-cycle, so compare on negedge.
  always @(negedge clk) begin
    kind_t       k;
    logic [31:0] e;
    logic [31:0] act;
    string       n;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_DOUT:  act = dout;
        K_REQ:   act = {31'd0, req};
        K_EPC:   act = epc_out;
        default: act = {31'd0, timer_irq};
      endcase
      checks++;
      if (act !== e) begin
        failures++;
        $display("[TB] FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    checkOutput(K_REQ, 0, "reset_req");
    checkOutput(K_EPC, 0, "reset_epc");
    checkOutput(K_TIRQ, 0, "reset_tirq");
    checkOutput(K_DOUT, 0, "reset_sr");
    cycle();

    // External interrupt path
    applyStimulus(1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 0, "t1_sr_pre_write");
    checkOutput(K_REQ, 0, "t1_req_idle");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 1, 0);
    checkOutput(K_DOUT, 32'h0000_0401, "t1_sr_written");
    checkOutput(K_REQ, 0, "t1_req_before_ip");
    cycle();
    applyStimulus(0, 13, 0, 32'h0000_3010, 0, 0, 1, 0);
    checkOutput(K_REQ, 1, "t1_req_int");
    checkOutput(K_DOUT, 32'h0000_0400, "t1_cause_ip10");
    cycle();
    applyStimulus(0, 12, 0, 32'h0000_3010, 0, 0, 1, 0);
    checkOutput(K_REQ, 0, "t1_req_masked_by_exl");
    checkOutput(K_EPC, 32'h0000_3010, "t1_epc");
    checkOutput(K_DOUT, 32'h0000_0403, "t1_sr_exl_set");
    cycle();
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'h0000_0400, "t1_cause_exccode0");
    cycle();
    applyStimulus(0, 14, 0, 0, 0, 0, 0, 1);
    checkOutput(K_DOUT, 32'h0000_3010, "t1_epc_read");
    checkOutput(K_REQ, 0, "t1_req_eret");
    cycle();

    // Exception in a delay slot
    applyStimulus(0, 12, 0, 32'h0000_3024, 1, 12, 0, 0);
    checkOutput(K_REQ, 1, "t2_req_exc");
    checkOutput(K_DOUT, 32'h0000_0401, "t2_sr_exl_cleared");
    cycle();
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0);
    checkOutput(K_EPC, 32'h0000_3020, "t2_epc_bd");
    checkOutput(K_DOUT, 32'h8000_0030, "t2_cause_bd_exc12");
    checkOutput(K_REQ, 0, "t2_req_after");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 1);
    checkOutput(K_DOUT, 32'h0000_0403, "t2_sr_exl_before_eret");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'h0000_0401, "t2_sr_exl_after_eret");
    cycle();

    // Interrupt beats exception; mtc0 suppressed by req
    applyStimulus(0, 14, 0, 0, 0, 0, 1, 0);
    checkOutput(K_REQ, 0, "t3_req_pre_ip");
    cycle();
    applyStimulus(1, 14, 32'h0000_1234, 32'h0000_3040, 0, 4, 1, 0);
    checkOutput(K_REQ, 1, "t3_req_both");
    checkOutput(K_DOUT, 32'h0000_3020, "t3_epc_pre");
    cycle();
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0);
    checkOutput(K_EPC, 32'h0000_3040, "t3_epc_write_suppressed");
    checkOutput(K_DOUT, 32'h0000_0400, "t3_cause_int_wins");
    cycle();
    applyStimulus(1, 14, 32'h0000_5677, 0, 0, 0, 0, 1);
    checkOutput(K_REQ, 0, "t3_req_mtc0_epc");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    checkOutput(K_EPC, 32'h0000_5674, "t3_epc_mtc0_aligned");
    checkOutput(K_DOUT, 32'h0000_0401, "t3_sr_exl_clear");
    cycle();
    applyStimulus(0, 12, 0, 32'h0000_3100, 0, 8, 0, 1);
    checkOutput(K_REQ, 1, "t3_req_with_eret");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'h0000_0403, "t3_req_beats_eret");
    checkOutput(K_EPC, 32'h0000_3100, "t3_epc_eret_cycle");
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput(K_DOUT, 0, "t3_unmapped_a0");
    cycle();

    // Timer interrupt
    applyStimulus(1, 11, 32'd10, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 9, 32'd0, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 12, 32'h0000_8001, 0, 0, 0, 0, 0);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
      checkOutput(K_DOUT, 32'(i), "t4_count");
      checkOutput(K_TIRQ, 0, "t4_tirq_low");
      checkOutput(K_REQ, 0, "t4_req_low");
      cycle();
    end
    applyStimulus(0, 13, 0, 32'h0000_3200, 0, 0, 0, 0);
    checkOutput(K_TIRQ, 1, "t4_tirq_set");
    checkOutput(K_REQ, 1, "t4_req_timer");
    checkOutput(K_DOUT, 32'h0000_8020, "t4_cause_ip15");
    cycle();
    applyStimulus(1, 11, 32'd100, 0, 0, 0, 0, 0);
    checkOutput(K_TIRQ, 1, "t4_tirq_sticky");
    checkOutput(K_REQ, 0, "t4_req_exl");
    checkOutput(K_EPC, 32'h0000_3200, "t4_epc");
    checkOutput(K_DOUT, 32'd10, "t4_compare_pre");
    cycle();
    applyStimulus(0, 11, 0, 0, 0, 0, 0, 1);
    checkOutput(K_TIRQ, 0, "t4_tirq_cleared");
    checkOutput(K_DOUT, 32'd100, "t4_compare_new");
    cycle();

    // Count wrap, PRId, unmapped
    applyStimulus(1, 9, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    cycle();
    applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'hFFFF_FFFF, "t5_count_max");
    cycle();
    applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'd0, "t5_count_wrap");
    cycle();
    applyStimulus(0, 15, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'h0000_5A01, "t5_prid");
    cycle();
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'd0, "t5_unmapped_a3");
    cycle();

    // Reset in the middle of an exception
    applyStimulus(0, 12, 0, 32'h0000_3300, 0, 5, 0, 0);
    checkOutput(K_REQ, 1, "t6_req_exc");
    cycle();
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'h0000_8003, "t6_sr_before_reset");
    checkOutput(K_EPC, 32'h0000_3300, "t6_epc_before_reset");
    cycle();
    reset = 1'b1;
    applyStimulus(0, 12, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    checkOutput(K_REQ, 0, "t6_req_after_reset");
    checkOutput(K_EPC, 0, "t6_epc_after_reset");
    checkOutput(K_TIRQ, 0, "t6_tirq_after_reset");
    checkOutput(K_DOUT, 0, "t6_sr_after_reset");
    cycle();
    applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'd1, "t6_count_restart");
    cycle();
    applyStimulus(0, 11, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'd0, "t6_compare_cleared");
    cycle();
    applyStimulus(0, 13, 0, 0, 0, 0, 0, 0);
    checkOutput(K_DOUT, 32'd0, "t6_cause_cleared");
    cycle();

    for (int i = 0; i < 4 && kind_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (kind_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_timer_ng.md
Name: cp0_timer_ng

Overview:
- Next-generation coprocessor-0 for the 5-stage MIPS pipeline. Instantiated in the M stage.
- Holds SR, Cause, EPC and PRId, plus a free-running Count/Compare timer.
- The number of external interrupt lines is a parameter; the timer drives an extra internal interrupt line.
- Produces the pipeline-wide exception/interrupt request `req` and the return address `epc_out`.

Parameters:
- HW_INT_N, 6, number of external interrupt lines. Constraint: 1 ≤ HW_INT_N+TIMER_EN ≤ 6.
- TIMER_EN, 0, 1 instantiates Count/Compare and timer interrupt; 0 makes Count/Compare read 0 and ignores writes to them.
- PRID, 32'h0000_5A01, constant value read from PRId (reg 15).
- VPC_W, 32, width of vpc/epc.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- we  in  1  mtc0 write enable (M stage)
- a  in  5  register address for read and write
- din  in  32  mtc0 write data
- dout  out  32  mfc0 read data (combinational)
- bd_in  in  1  M-stage instruction is in a delay slot
- vpc  in  VPC_W  M-stage PC
- exc_code_in  in  5  M-stage exception code; 0 means none
- hw_int  in  HW_INT_N  external interrupt lines, level-sensitive
- exl_clr  in  1  eret in M stage
- req  out  1  take exception/interrupt this cycle (combinational)
- epc_out  out  VPC_W  current EPC register
- timer_irq  out  1  registered timer-pending flag

Behaviour:
- **Reset:** synchronous, active-high. Clears SR, Cause, EPC, Count, Compare and timer_pend. Therefore epc_out=0, timer_irq=0, req=0.
- **Register map** (reads of unmapped addresses return 0):
  - 12 SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; read-only to mtc0.
  - 14 EPC.
  - 15 PRId.
  - 9 Count.
  - 11 Compare.
- **IP map:**
  - IP[10+i] = registered hw_int[i], for i < HW_INT_N.
  - If TIMER_EN=1, IP[10+HW_INT_N] = timer_pend.
  - Unused IP bits are 0.
  - IP is sampled every cycle, so hw_int reaches IP one cycle after being asserted.
- **Request logic:**
  - int_req = IE & ~EXL & |(IP & IM), where IP here is the live value: registered hw_int bits OR timer_pend.
  - exc_req = (exc_code_in != 0) & ~EXL.
  - req = int_req | exc_req.
- **On a clock edge with req=1:**
  - EXL ← 1.
  - Cause.BD ← bd_in.
  - ExcCode ← 0 if int_req, otherwise exc_code_in. Interrupt has priority over exception.
  - EPC ← (bd_in ? vpc-4 : vpc) with bits [1:0] forced to 0.
- **mtc0:** when we=1 and req=0, write the register at `a`.
  - SR stores only its defined bits.
  - EPC stores din[VPC_W-1:0] & ~3.
  - When req=1, the mtc0 write is suppressed.
- **exl_clr:** clears EXL on the edge. If req and exl_clr are both 1, req wins and EXL stays 1.
- **Timer** (TIMER_EN=1):
  - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF → 0.
  - mtc0 to Count loads din in place of the increment.
  - timer_pend sets on the edge where Count == Compare and Compare != 0.
  - mtc0 to Compare clears timer_pend and takes priority over a same-cycle set.
  - Timer state is unaffected by req and EXL.
- **Reads:** dout is combinational and returns the register contents before the edge. No internal write-to-read bypass; the pipeline stalls eret behind an mtc0 to EPC.
- **Latency:**
  - req is combinational.
  - EPC, Cause and SR update 1 cycle after req.
  - The timer raises timer_irq 1 cycle after the Count==Compare edge.

Test Plan:
1. Reset, then set SR=32'h0000_0401 (IM[10], IE); raise hw_int[0] → IP[10]=1 next cycle and req=1 that cycle. With vpc=32'h0000_3010, bd_in=0: after the edge EPC=32'h3010, EXL=1, ExcCode=0, req=0.
2. exc_code_in=5'd12, vpc=32'h3024, bd_in=1, EXL=0 → req=1; EPC=32'h3020, Cause.BD=1, ExcCode=12. Then exl_clr=1 → EXL=0.
3. Same cycle: exc_code_in=4 and an enabled interrupt pending → ExcCode=0 (interrupt wins). Same cycle: we=1, a=14, din=32'h1234 with req=1 → EPC holds the exception value, not 32'h1234.
4. TIMER_EN=1, HW_INT_N=5: write Compare=10, Count=0, SR=32'h0000_8001 (IM[15], IE) → timer_irq rises the cycle after Count==10, and req asserts. Writing Compare=100 clears timer_irq.
5. Count written to 32'hFFFF_FFFF → reads 0 one cycle later (wrap). Reads of a=15 return PRID; reads of a=3 return 0.
6. Assert reset mid-exception (EXL=1, timer running) → all registers 0, req=0 on the following cycle.
